regfile_write_scheduler: RTL and testbench

//   Sequences and shares the single write port of the 32x32 register file (Registers_file).

---
 rtl/mips_regfile_pkg.sv | 14 +
 rtl/regfile_write_scheduler_rr_arb2.sv | 36 +++
 rtl/regfile_write_scheduler.sv | 112 +++++++++++
 tb/tb_regfile_write_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared constants and state type for the register-file write scheduler.
package mips_regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    ARB  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/regfile_write_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: holds the priority pointer, emits a one-hot grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic gnt_a,
  output logic gnt_b
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Grant the only requester, or the pointed-to side when both request.
  always_comb begin
    gnt_a    = en && a_valid && (!b_valid || !rr_ptr_q);
    gnt_b    = en && b_valid && !gnt_a;
    rr_ptr_d = rr_ptr_q;
    if (gnt_a) begin
      rr_ptr_d = 1'b1;
    end else if (gnt_b) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Pointer moves to the other side only on a completed transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: clear walk after reset, then
// round-robin sharing between writeback (A) and load-return (B).
module regfile_write_scheduler #(
  parameter int unsigned DATA_W     = mips_regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W     = mips_regfile_pkg::ADDR_W,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wen,
  output logic              init_busy
);

  import mips_regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

  sched_state_t    state_q, state_d;
  logic [ADDR_W:0] init_idx_q, init_idx_d;
  logic            arb_en;
  logic            gnt_a, gnt_b;

  assign arb_en = rst && (state_q == ARB);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  // Clear-walk sequencing: one register per cycle, then hand over to ARB.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == LAST_IDX) begin
        state_d = ARB;
      end
    end
  end

  // State and walk index, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= (INIT_CLEAR != 0) ? INIT : ARB;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Write-port mux and hazard compare; outputs are held quiet while rst is low.
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    rf_wen    = 1'b0;
    rf_dest   = '0;
    rf_wdata  = '0;
    hazard1   = 1'b0;
    hazard2   = 1'b0;
    init_busy = 1'b0;
    if (!rst) begin
      init_busy = 1'b1;
    end else if (state_q == INIT) begin
      init_busy = 1'b1;
      rf_wen    = 1'b1;
      rf_dest   = init_idx_q[ADDR_W-1:0];
    end else begin
      a_ready = gnt_a;
      b_ready = gnt_b;
      if (gnt_a) begin
        rf_dest  = a_dest;
        rf_wdata = a_data;
        rf_wen   = (a_dest != ZERO_IDX);
      end else if (gnt_b) begin
        rf_dest  = b_dest;
        rf_wdata = b_data;
        rf_wen   = (b_dest != ZERO_IDX);
      end
      // The granted request commits at this edge, so it is never a hazard.
      hazard1 = (src1 != ZERO_IDX) &&
                ((a_valid && !gnt_a && a_dest == src1) ||
                 (b_valid && !gnt_b && b_dest == src1));
      hazard2 = (src2 != ZERO_IDX) &&
                ((a_valid && !gnt_a && a_dest == src2) ||
                 (b_valid && !gnt_b && b_dest == src2));
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a per-cycle reference model.
module tb_regfile_write_scheduler;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_dest, b_dest;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [4:0]  src1, src2;
  logic        hazard1, hazard2;
  logic [4:0]  rf_dest;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        init_busy;

  int errors = 0;
  int checks = 0;

  regfile_write_scheduler #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .NUM_REGS   (32),
    .INIT_CLEAR (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_dest    (a_dest),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_dest    (b_dest),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .src1      (src1),
    .src2      (src2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .rf_dest   (rf_dest),
    .rf_wdata  (rf_wdata),
    .rf_wen    (rf_wen),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walk counter, "B goes next" flag, and register contents.
  bit          m_arb = 1'b0;
  int          m_idx = 0;
  bit          m_next_b = 1'b0;
  logic [31:0] m_regs [32];

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hDEAD_BEEF;
  end

  // Compare every cycle at negedge, then advance the model at the posedge.
  always begin : compare
    bit          ga, gb;
    bit          e_ar, e_br, e_wen, e_busy, e_h1, e_h2;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    @(negedge clk);
    ga = 0; gb = 0; e_ar = 0; e_br = 0; e_wen = 0; e_busy = 0;
    e_h1 = 0; e_h2 = 0; e_dest = '0; e_data = '0;
    if (!rst) begin
      e_busy = 1;
    end else if (!m_arb) begin
      e_busy = 1; e_wen = 1; e_dest = 5'(m_idx);
    end else begin
      ga = a_valid && !(b_valid && m_next_b);
      gb = b_valid && !ga;
      e_ar = ga; e_br = gb;
      if (ga) begin
        e_dest = a_dest; e_data = a_data; e_wen = (a_dest != 0);
      end else if (gb) begin
        e_dest = b_dest; e_data = b_data; e_wen = (b_dest != 0);
      end
      e_h1 = (src1 != 0) && ((a_valid && !ga && a_dest == src1) || (b_valid && !gb && b_dest == src1));
      e_h2 = (src2 != 0) && ((a_valid && !ga && a_dest == src2) || (b_valid && !gb && b_dest == src2));
    end
    chk("m_a_ready", 32'(a_ready), 32'(e_ar));
    chk("m_b_ready", 32'(b_ready), 32'(e_br));
    chk("m_rf_wen", 32'(rf_wen), 32'(e_wen));
    chk("m_rf_dest", 32'(rf_dest), 32'(e_dest));
    chk("m_rf_wdata", rf_wdata, e_data);
    chk("m_hazard1", 32'(hazard1), 32'(e_h1));
    chk("m_hazard2", 32'(hazard2), 32'(e_h2));
    chk("m_init_busy", 32'(init_busy), 32'(e_busy));
    @(posedge clk);
    if (!rst) begin
      m_arb = 0; m_idx = 0; m_next_b = 0;
    end else if (!m_arb) begin
      m_regs[m_idx] = '0;
      m_idx++;
      if (m_idx == 32) m_arb = 1;
    end else if (ga) begin
      if (a_dest != 0) m_regs[a_dest] = a_data;
      m_next_b = 1;
    end else if (gb) begin
      if (b_dest != 0) m_regs[b_dest] = b_data;
      m_next_b = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int n;
    int bad;
    rst = 0; a_valid = 0; b_valid = 0; a_dest = '0; b_dest = '0;
    a_data = '0; b_data = '0; src1 = '0; src2 = '0;

    // 1. reset for two cycles, then a 32-cycle clear walk
    tick; tick;
    chk("reset_wen", 32'(rf_wen), 32'd0);
    chk("reset_busy", 32'(init_busy), 32'd1);
    rst = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      chk("walk_dest", 32'(rf_dest), 32'(n));
      chk("walk_wen", 32'(rf_wen), 32'd1);
      chk("walk_wdata", rf_wdata, 32'd0);
      n++;
    end
    chk("walk_len", 32'(n), 32'd32);
    tick;
    bad = 0;
    for (int i = 0; i < 32; i++) if (m_regs[i] !== 32'd0) bad++;
    chk("model_cleared", 32'(bad), 32'd0);

    // 2. A writes r1=5, granted the same cycle
    a_valid = 1; a_dest = 5'd1; a_data = 32'd5;
    @(negedge clk);
    chk("t2_a_ready", 32'(a_ready), 32'd1);
    chk("t2_wen", 32'(rf_wen), 32'd1);
    chk("t2_dest", 32'(rf_dest), 32'd1);
    chk("t2_wdata", rf_wdata, 32'd5);
    tick;
    a_valid = 0; src1 = 5'd1;
    chk("t2_r1", m_regs[1], 32'd5);

    // B-only write moves priority back to A
    b_valid = 1; b_dest = 5'd3; b_data = 32'd9;
    @(negedge clk);
    chk("pre3_b_ready", 32'(b_ready), 32'd1);
    tick;
    b_valid = 0;

    // 3. A and B together: A, B, then A again on its new request
    a_valid = 1; a_dest = 5'd20; a_data = 32'd25;
    b_valid = 1; b_dest = 5'd21; b_data = 32'd7;
    @(negedge clk);
    chk("t3_g1_a", 32'(a_ready), 32'd1);
    chk("t3_g1_b", 32'(b_ready), 32'd0);
    tick;
    a_dest = 5'd22; a_data = 32'd33;
    @(negedge clk);
    chk("t3_g2_b", 32'(b_ready), 32'd1);
    chk("t3_g2_a", 32'(a_ready), 32'd0);
    tick;
    b_valid = 0;
    @(negedge clk);
    chk("t3_g3_a", 32'(a_ready), 32'd1);
    chk("t3_g3_dest", 32'(rf_dest), 32'd22);
    tick;
    a_valid = 0;
    chk("t3_r20", m_regs[20], 32'd25);
    chk("t3_r21", m_regs[21], 32'd7);

    // 4. A write to r0 handshakes but does not write
    a_valid = 1; a_dest = 5'd0; a_data = 32'd5;
    @(negedge clk);
    chk("t4_a_ready", 32'(a_ready), 32'd1);
    chk("t4_wen", 32'(rf_wen), 32'd0);
    tick;
    a_valid = 0;
    chk("t4_r0", m_regs[0], 32'd0);

    // B-only write to hand priority to A
    b_valid = 1; b_dest = 5'd4; b_data = 32'd1;
    tick;
    b_valid = 0;

    // 5. B pending on r30 while A wins: hazard2 then clear on grant
    a_valid = 1; a_dest = 5'd5; a_data = 32'd2;
    b_valid = 1; b_dest = 5'd30; b_data = 32'd77;
    src2 = 5'd30;
    @(negedge clk);
    chk("t5_a_ready", 32'(a_ready), 32'd1);
    chk("t5_haz2_wait", 32'(hazard2), 32'd1);
    chk("t5_haz1", 32'(hazard1), 32'd0);
    tick;
    a_valid = 0;
    @(negedge clk);
    chk("t5_b_ready", 32'(b_ready), 32'd1);
    chk("t5_haz2_grant", 32'(hazard2), 32'd0);
    tick;
    b_valid = 0; src2 = '0;

    // 6. reset mid-walk at index 10, with a request pending
    rst = 0;
    tick;
    rst = 1;
    for (int i = 0; i < 10; i++) tick;
    chk("t6_idx10", 32'(rf_dest), 32'd10);
    rst = 0;
    a_valid = 1; a_dest = 5'd7; a_data = 32'd99;
    @(negedge clk);
    chk("t6_rst_ready", 32'(a_ready), 32'd0);
    chk("t6_rst_wen", 32'(rf_wen), 32'd0);
    chk("t6_rst_busy", 32'(init_busy), 32'd1);
    tick;
    rst = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      chk("t6_walk_dest", 32'(rf_dest), 32'(n));
      chk("t6_no_ready", 32'(a_ready), 32'd0);
      n++;
    end
    chk("t6_walk_len", 32'(n), 32'd32);
    chk("t6_late_grant", 32'(a_ready), 32'd1);
    tick;
    a_valid = 0;
    chk("t6_r7", m_regs[7], 32'd99);
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
